// File: rtl/nios_avalon_st_packet_tx_if.sv
// rtl/nios_avalon_st_packet_tx_if.sv - write port and Avalon-ST source signals of the packet transmitter
// master is the transmitter's view; slave is the producer/sink environment.
interface nios_avalon_st_packet_tx_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        wr_last;
  logic [1:0]  wr_empty;
  logic        wr_error;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_error;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;

  modport master (
    input  wr_valid, wr_data, wr_last, wr_empty, wr_error, out_ready,
    output wr_ready, out_valid, out_data, out_error, out_startofpacket,
    output out_endofpacket, out_empty
  );

  modport slave (
    output wr_valid, wr_data, wr_last, wr_empty, wr_error, out_ready,
    input  wr_ready, out_valid, out_data, out_error, out_startofpacket,
    input  out_endofpacket, out_empty
  );
endinterface

// File: rtl/nios_avalon_st_packet_tx.sv
// rtl/nios_avalon_st_packet_tx.sv - store-and-forward Avalon-ST packet source with ready latency
// Buffers whole packets in a FIFO; oversize packets are cut through with the error flag forced.
module nios_avalon_st_packet_tx #(
  parameter int  DEPTH         = 16,
  parameter int  READY_LATENCY = 1,
  parameter int  CNT_W         = 16,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  nios_avalon_st_packet_tx_if.master st,
  output logic [CNT_W-1:0]           pkt_count,
  output logic [AW:0]                fill_level
);
  typedef enum logic [1:0] {IDLE, SEND, CUT} state_t;

  localparam logic [AW:0]      FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]      LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [35:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic [AW:0]      pkts_buf_q;
  logic [AW:0]      pkts_buf_d;
  state_t           state_q;
  logic             sop_q;
  logic [CNT_W-1:0] pkt_count_q;

  logic        permit;
  logic        wr_fire;
  logic        xfer;
  logic [31:0] head_data;
  logic        head_error;
  logic        head_last;
  logic [1:0]  head_empty;

  assign st.wr_ready = reset_n && (count_q != FULL_LVL);
  assign wr_fire     = st.wr_valid && st.wr_ready;
  assign {head_data, head_error, head_last, head_empty} = mem_q[rd_ptr_q];

  generate
    if (READY_LATENCY == 0) begin : g_rl0
      assign permit = 1'b1;
    end else begin : g_rlp
      logic [READY_LATENCY-1:0] rdy_pipe_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdy_pipe_q <= '0;
        end else begin
          rdy_pipe_q <= (rdy_pipe_q << 1) | (READY_LATENCY)'(st.out_ready);
        end
      end
      assign permit = rdy_pipe_q[READY_LATENCY-1];
    end
  endgenerate

  // With a nonzero ready latency the permit already encodes the sink's promise to accept.
  assign st.out_valid = (state_q != IDLE) && (count_q != '0) && permit;
  assign xfer         = st.out_valid && ((READY_LATENCY != 0) || st.out_ready);

  always_comb begin
    count_d    = count_q;
    pkts_buf_d = pkts_buf_q;
    if (wr_fire) count_d = count_d + LVL_ONE;
    if (xfer) count_d = count_d - LVL_ONE;
    if (wr_fire && st.wr_last) pkts_buf_d = pkts_buf_d + LVL_ONE;
    if (xfer && head_last) pkts_buf_d = pkts_buf_d - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= {st.wr_data, st.wr_error, st.wr_last, st.wr_empty};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkts_buf_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (xfer) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q    <= count_d;
      pkts_buf_q <= pkts_buf_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sop_q       <= 1'b1;
      pkt_count_q <= '0;
    end else begin
      if (xfer) begin
        sop_q <= head_last;
        if (head_last) pkt_count_q <= pkt_count_q + CNT_ONE;
      end
      case (state_q)
        // A full FIFO with no complete packet can only drain by cutting through.
        IDLE: begin
          if (pkts_buf_q != '0) state_q <= SEND;
          else if (count_q == FULL_LVL) state_q <= CUT;
        end
        SEND, CUT: begin
          if (xfer && head_last) state_q <= (pkts_buf_d != '0) ? SEND : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign st.out_data          = st.out_valid ? head_data : 32'h0;
  assign st.out_error         = st.out_valid && (head_error || (state_q == CUT));
  assign st.out_startofpacket = st.out_valid && sop_q;
  assign st.out_endofpacket   = st.out_valid && head_last;
  assign st.out_empty         = (st.out_valid && head_last) ? head_empty : 2'b00;
  assign pkt_count            = pkt_count_q;
  assign fill_level           = count_q;
endmodule

// File: doc/nios_avalon_st_packet_tx.md
Name: nios_avalon_st_packet_tx

Overview:
Store-and-forward Avalon-ST packet transmitter. It is the source end of a 32-bit packet stream with 2-bit empty, 1-bit error, SOP and EOP.
- Accepts words from a simple write port, buffers whole packets, and transmits each packet contiguously.
- Drives out_startofpacket and out_endofpacket itself, and honours a configurable downstream ready latency.
- Feeds the stream timing adapters in the Nios subsystem.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 4
READY_LATENCY, 1, downstream readyLatency; legal values 0..3
CNT_W, 16, width of the transmitted-packet counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
wr_valid  in  1  write word offered
wr_ready  out  1  word accepted when wr_valid && wr_ready
wr_data  in  32  payload word
wr_last  in  1  word is last of packet
wr_empty  in  2  empty bytes in last word; ignored unless wr_last
wr_error  in  1  per-word error flag
out_ready  in  1  downstream ready
out_valid  out  1  beat valid
out_data  out  32  payload
out_error  out  1  error
out_startofpacket  out  1  first beat of packet
out_endofpacket  out  1  last beat of packet
out_empty  out  2  empty bytes; nonzero only with EOP
pkt_count  out  CNT_W  packets transmitted, wraps
fill_level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - FIFO, counters, FSM and ready pipe cleared.
  - All outputs 0, except wr_ready, which is 1 once reset_n is high.
- Reset mid-packet discards all buffered and partially sent data. The downstream never sees that packet's EOP.
- FIFO:
  - Entry = {data, error, last, empty}.
  - wr_ready = (fill_level != DEPTH), combinational.
  - fill_level increments on each accepted write and decrements on each transmitted beat. Simultaneous write and transmit leaves it unchanged.
  - Pointers wrap modulo DEPTH.
- Complete-packet counter pkts_buf:
  - +1 on an accepted write with wr_last.
  - -1 on a transmitted beat with EOP.
  - Both in the same cycle: net 0.
- Permit signal:
  - READY_LATENCY=0: permit = 1.
  - Otherwise: permit = out_ready delayed READY_LATENCY cycles through a shift register that resets to 0.
- FSM states: IDLE, SEND, CUT.
  - IDLE -> SEND when pkts_buf != 0.
  - IDLE -> CUT when fill_level == DEPTH and pkts_buf == 0 (oversize packet; prevents deadlock).
  - SEND/CUT on a transmitted EOP beat: go to SEND if pkts_buf after update != 0, else IDLE. Packets may go back-to-back with no idle cycle.
  - CUT on a non-EOP beat: stay in CUT.
- Output beat:
  - out_valid = (state != IDLE) && FIFO not empty && permit.
  - With READY_LATENCY=0, out_valid must not depend on out_ready, and transfer = out_valid && out_ready.
  - With READY_LATENCY>=1, transfer = out_valid; the sink must accept.
  - In CUT, FIFO-empty cycles drop out_valid (underrun allowed only in CUT).
- Payload:
  - out_data and out_error come from the FIFO head; out_error is forced to 1 on every beat while in CUT.
  - out_endofpacket = head.last.
  - out_empty = head.last ? head.empty : 0.
  - All payload and SOP/EOP outputs are 0 when out_valid = 0.
- SOP flag:
  - Set on reset and after each transmitted EOP; cleared after any transmitted beat without EOP.
  - out_startofpacket = flag && out_valid.
  - A single-word packet carries SOP and EOP on the same beat.
- pkt_count increments on each transmitted EOP beat and wraps from 2^CNT_W-1 to 0.
- Zero-cycle write-to-read bypass is not permitted. A word is transmittable at the earliest one cycle after it is written.

Test Plan:
- RL=1: write a 3-word packet (0xA0,0xA1,0xA2, last with empty=2), out_ready held 1 -> no out_valid before the last word is written; 3 consecutive beats with SOP on beat 1, EOP+empty=2 on beat 3; pkt_count=1; fill_level=0.
- RL=2, out_ready toggling 1,0,1,0 -> out_valid high exactly 2 cycles after each out_ready=1 cycle and never otherwise; data order preserved.
- RL=0: two back-to-back 1-word packets, out_ready low for 5 cycles -> out_valid held with stable data; on out_ready each beat has SOP=EOP=1; no idle cycle between packets; pkt_count=2.
- DEPTH=16: write 16 words with no last -> wr_ready=0 at fill 16; FSM enters CUT; beats carry out_error=1; the final word written later with last gives EOP; state returns to IDLE.
- Simultaneous write of a last word and transmit of an EOP beat with pkts_buf=1 -> pkts_buf stays 1; the next packet starts with SOP; fill_level unchanged that cycle.
- Assert reset_n=0 mid-packet (after beat 2 of 4) -> outputs 0 asynchronously; after release fill_level=0, pkt_count=0, wr_ready=1; a new packet is transmitted correctly with SOP.
